adc_serial_capture: RTL and testbench
=====================================

Name: adc_serial_capture

Overview:
- Consumes the divided ADC serial clock (adcclock) produced by the clock divider.
- Runs a serial ADC (ADC0831-style: CS_n low, lead-in clocks, then MSB-first data) and deserialises each conversion into a parallel word.
- Presents each word to the downstream EEPROM write controller through a one-entry valid/ready buffer.
- Everything runs in the clk domain. adcclock is treated as a clock-enable source via edge detection and is never used as a clock.

Parameters:
- DATA_WIDTH, 8: bits per conversion, shifted MSB first.
- LEAD_CLKS, 2: adcclock rising edges after CS_n falls before the first data bit (mux settle + start/null bit).
- GAP_CLKS, 4: adcclock rising edges CS_n stays high between conversions; minimum 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-low reset.
- adcclock, input, 1: divided ADC serial clock, synchronous to clk, 50%-ish duty.
- enable, input, 1: level; 1 = convert continuously.
- adc_dout, input, 1: serial data from ADC, asynchronous to clk.
- adc_cs_n, output, 1: ADC chip select, active low.
- sample, output, DATA_WIDTH: captured conversion result.
- sample_valid, output, 1: sample holds an unconsumed word.
- sample_ready, input, 1: consumer accepts the word.
- overrun, output, 1: sticky; a completed conversion was dropped.
- clear_overrun, input, 1: synchronous clear of overrun.
- busy, output, 1: 1 whenever state != IDLE.

Behaviour:
- Reset (rst=0, async): all state cleared.
  - adc_cs_n=1, sample=0, sample_valid=0, overrun=0, busy=0.
  - Shift register, counters and edge-detect/sync flops cleared; state=IDLE.
- adc_dout passes through a 2-flop synchroniser. adcclock is registered once (adc_q).
  - rise = adcclock & ~adc_q; fall = ~adcclock & adc_q.
  - Each is a single-clk pulse, one clk after the adcclock transition.
- FSM states: IDLE, ARM, LEAD, SHIFT, GAP.
  - IDLE: adc_cs_n=1. If enable=1, go to ARM.
  - ARM: wait for fall. On fall, drive adc_cs_n=0 (registered, effective next clk) and go to LEAD with lead counter=0. CS therefore always drops while adcclock is low.
  - LEAD: count rise pulses. On the LEAD_CLKS-th rise, go to SHIFT with bit counter=0.
  - SHIFT: on each rise, shift the synchronised adc_dout into the LSB of the shift register (MSB arrives first).
    - On the DATA_WIDTH-th rise: adc_cs_n=1, the word completes, go to GAP.
  - GAP: count rise pulses with adc_cs_n=1. After GAP_CLKS rises, go to ARM if enable=1, else IDLE.
- enable is sampled only in IDLE and at GAP exit. Deasserting it mid-conversion never truncates a conversion.
- Conversion length: LEAD_CLKS+DATA_WIDTH adcclock periods with CS low.
  - Period between starts with enable held: LEAD_CLKS+DATA_WIDTH+GAP_CLKS periods, plus ARM wait of up to 1 period.
- Output buffer, on word completion (same clk as the last rise):
  - If sample_valid=0, or sample_ready=1 in that clk: sample<=word and sample_valid<=1 on the next clk. Load and handshake in the same cycle are allowed.
  - Otherwise the word is dropped, sample is unchanged, and overrun<=1.
- sample_valid falls the clk after sample_valid&sample_ready when no new word loads. sample is held stable while sample_valid=1.
- overrun clears on clear_overrun=1. A simultaneous set and clear resolves to set.
- Counters are sized to hold max(LEAD_CLKS, DATA_WIDTH, GAP_CLKS). No wrap occurs because each counter resets on state entry.
- adcclock held static (divider in reset): FSM stalls in its current state with outputs held. No timeout.
- rst low mid-SHIFT: adc_cs_n=1 immediately (async). The partial word is discarded and never presented.

Test Plan:
- Reset/idle: rst=0, then release with enable=0 and adcclock toggling at clk/8 → adc_cs_n=1, sample_valid=0, busy=0 for 50 clks.
- Single conversion: enable=1 for one GAP period, bench ADC model drives 0xA5 MSB first, changing on adcclock falls, sample_ready=1.
  - adc_cs_n falls after an adcclock fall and stays low exactly 10 adcclock periods.
  - sample=0xA5; sample_valid is high 1 clk, one clk after the 10th rise.
- Back-to-back: enable held, words 0x00, 0xFF, 0x3C, sample_ready=1 → three words in order; CS_n high ≥4 rises between conversions.
- Backpressure/overrun: sample_ready=0, two conversions 0x11 then 0x22.
  - sample stays 0x11, overrun=1.
  - clear_overrun pulse gives overrun=0; sample_ready=1 gives a handshake on 0x11 only.
- Simultaneous load/accept: sample_ready asserted in the exact clk the second word completes → sample_valid stays 1, sample updates to the second word, overrun=0.
- Reset mid-SHIFT: rst=0 after 4 data bits → adc_cs_n=1 asynchronously, sample_valid=0. After release with the ADC model driving 0x5A, the next word is 0x5A with no residue.

Source files
------------

// File: rtl/adc_serial_capture.sv
// ADC0831-style serial capture: drives CS_n, deserialises MSB-first data on adcclock
// rising edges (used only as a clock enable), and hands words on through a one-entry buffer.
`timescale 1ns/1ps
module adc_serial_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int LEAD_CLKS  = 2,
  parameter int GAP_CLKS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adcclock,
  input  logic                  enable,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  input  logic                  clear_overrun,
  output logic                  busy
);

  localparam int MAX_LD  = (LEAD_CLKS > DATA_WIDTH) ? LEAD_CLKS : DATA_WIDTH;
  localparam int MAX_CNT = (MAX_LD > GAP_CLKS) ? MAX_LD : GAP_CLKS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_CLKS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {IDLE, ARM, LEAD, SHIFT, GAP} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic                    cs_n_reg, cs_n_next;
  logic                    adc_q_reg;
  logic [1:0]              dout_sync_reg;
  logic [DATA_WIDTH-1:0]   sample_reg;
  logic                    valid_reg;
  logic                    overrun_reg;

  logic rise, fall, word_done, load;

  assign rise = adcclock & ~adc_q_reg;
  assign fall = ~adcclock & adc_q_reg;

  // State register plus the datapath registers that follow it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      cs_n_reg      <= 1'b1;
      adc_q_reg     <= 1'b0;
      dout_sync_reg <= 2'b00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      cs_n_reg      <= cs_n_next;
      adc_q_reg     <= adcclock;
      dout_sync_reg <= {dout_sync_reg[0], adc_dout};
    end
  end

  // Next-state logic; enable is only looked at in IDLE and when GAP ends
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = ARM;
      ARM:     if (fall) state_next = LEAD;
      LEAD:    if (rise && cnt_reg == LEAD_LAST) state_next = SHIFT;
      SHIFT:   if (rise && cnt_reg == DATA_LAST) state_next = GAP;
      GAP:     if (rise && cnt_reg == GAP_LAST) state_next = enable ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    word_done  = 1'b0;
    // every state entry restarts the edge counter, so it never wraps
    if (state_next != state_reg)
      cnt_next = '0;
    else if (rise && (state_reg == LEAD || state_reg == SHIFT || state_reg == GAP))
      cnt_next = cnt_reg + 1'b1;
    if (state_reg == SHIFT && rise)
      shift_next = {shift_reg[DATA_WIDTH-2:0], dout_sync_reg[1]};
    if (state_reg == SHIFT && rise && cnt_reg == DATA_LAST)
      word_done = 1'b1;
    cs_n_next = !(state_next == LEAD || state_next == SHIFT);
  end

  // A finished word loads if the slot is free or is being emptied this same cycle
  assign load = word_done && (!valid_reg || sample_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (load) begin
        sample_reg <= shift_next;
        valid_reg  <= 1'b1;
      end else if (valid_reg && sample_ready) begin
        valid_reg  <= 1'b0;
      end
      if (word_done && !load)
        overrun_reg <= 1'b1;
      else if (clear_overrun)
        overrun_reg <= 1'b0;
    end
  end

  assign adc_cs_n     = cs_n_reg;
  assign sample       = sample_reg;
  assign sample_valid = valid_reg;
  assign overrun      = overrun_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: behavioural ADC0831 model, table of single conversions,
// then hand-written back-to-back, backpressure, load/accept and reset-mid-shift sequences.
`timescale 1ns/1ps
module tb_adc_serial_capture;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          adcclock = 1'b0;
  logic          enable = 1'b0;
  logic          adc_dout = 1'b0;
  logic          sample_ready = 1'b0;
  logic          clear_overrun = 1'b0;
  logic          adc_cs_n;
  logic          sample_valid;
  logic          overrun;
  logic          busy;
  logic [DW-1:0] sample;

  int passed = 0;
  int total  = 0;

  adc_serial_capture #(.DATA_WIDTH(DW), .LEAD_CLKS(2), .GAP_CLKS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .adcclock     (adcclock),
    .enable       (enable),
    .adc_dout     (adc_dout),
    .adc_cs_n     (adc_cs_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // adcclock = clk/8, changing just after a clk edge
  int div_cnt = 0;
  always @(posedge clk) begin
    #1;
    div_cnt++;
    if (div_cnt == 4) begin
      div_cnt = 0;
      adcclock = ~adcclock;
    end
  end

  // ADC model: 1st fall with CS low is mux settle, bits change on falls 2..9, MSB first
  logic [7:0] adc_words[$];
  logic [7:0] cur_word = 8'h00;
  int         fall_cnt = 0;
  always @(negedge adcclock) begin
    if (adc_cs_n) begin
      fall_cnt = 0;
    end else begin
      fall_cnt++;
      if (fall_cnt == 1)
        cur_word = (adc_words.size() > 0) ? adc_words.pop_front() : 8'h00;
      if (fall_cnt >= 2 && fall_cnt <= 9)
        adc_dout = cur_word[9 - fall_cnt];
    end
  end

  // Monitor of CS timing relative to adcclock
  int   low_rises = 0, high_rises = 0, last_low = 0, last_gap = 0;
  logic mon_adc_prev = 1'b0, mon_cs_prev = 1'b1, cs_fall_adc_low = 1'b0;
  always @(negedge clk) begin
    if (adcclock && !mon_adc_prev) begin
      if (adc_cs_n) high_rises++;
      else          low_rises++;
    end
    if (mon_cs_prev && !adc_cs_n) begin
      last_gap        = high_rises;
      high_rises      = 0;
      low_rises       = 0;
      cs_fall_adc_low = !adcclock;
    end
    if (!mon_cs_prev && adc_cs_n)
      last_low = low_rises;
    mon_adc_prev = adcclock;
    mon_cs_prev  = adc_cs_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2 ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    else begin
      passed++;
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (sample_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sample_valid), 32'd1);
  endtask

  task automatic wait_busy(input string name, input logic val, input int budget);
    int n;
    n = 0;
    while (busy !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'(val));
  endtask

  task automatic wait_cs(input string name, input logic val, input int budget);
    int n;
    n = 0;
    while (adc_cs_n !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(adc_cs_n), 32'(val));
  endtask

  task automatic wait_overrun(input string name, input int budget);
    int n;
    n = 0;
    while (overrun !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(overrun), 32'd1);
  endtask

  task automatic count_rises(input string name, input int want, input int budget);
    int   seen, cyc;
    logic prev;
    seen = 0;
    cyc  = 0;
    prev = adcclock;
    while (seen < want && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (adcclock && !prev) seen++;
      prev = adcclock;
    end
    check(name, 32'(seen), 32'(want));
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_sample;
    int         exp_low_rises;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] exp_b2b[3];
  int         bad;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 10};
    vecs[1] = '{8'h01, 8'h01, 10};
    vecs[2] = '{8'h80, 8'h80, 10};
    vecs[3] = '{8'h96, 8'h96, 10};
    exp_b2b[0] = 8'h00;
    exp_b2b[1] = 8'hFF;
    exp_b2b[2] = 8'h3C;

    // Reset state, then idle with enable low
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (adc_cs_n !== 1'b1 || sample_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_50clk_bad_cycles", 32'(bad), 32'd0);

    // Table of single conversions with sample_ready held high
    sample_ready = 1'b1;
    foreach (vecs[i]) begin
      adc_words.push_back(vecs[i].word);
      enable = 1'b1;
      wait_busy($sformatf("vec%0d_start", i), 1'b1, 20);
      enable = 1'b0;
      wait_valid($sformatf("vec%0d_valid", i), 300);
      check($sformatf("vec%0d_cs_high_at_valid", i), 32'(adc_cs_n), 32'd1);
      check($sformatf("vec%0d_sample", i), 32'(sample), 32'(vecs[i].exp_sample));
      @(negedge clk);
      check($sformatf("vec%0d_valid_one_clk", i), 32'(sample_valid), 32'd0);
      check($sformatf("vec%0d_cs_low_rises", i), 32'(last_low), 32'(vecs[i].exp_low_rises));
      check($sformatf("vec%0d_cs_fell_adc_low", i), 32'(cs_fall_adc_low), 32'd1);
      wait_busy($sformatf("vec%0d_idle", i), 1'b0, 100);
    end

    // Back-to-back conversions with enable held
    foreach (exp_b2b[i]) adc_words.push_back(exp_b2b[i]);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid($sformatf("b2b%0d_valid", i), 400);
      check($sformatf("b2b%0d_sample", i), 32'(sample), 32'(exp_b2b[i]));
      if (i > 0)
        check($sformatf("b2b%0d_gap_ge4", i), 32'(last_gap >= 4), 32'd1);
      if (i == 2) enable = 1'b0;
      @(negedge clk);
    end
    wait_busy("b2b_idle", 1'b0, 200);

    // Backpressure: second word is dropped and flags overrun
    sample_ready = 1'b0;
    adc_words.push_back(8'h11);
    adc_words.push_back(8'h22);
    enable = 1'b1;
    wait_valid("bp_first_valid", 300);
    check("bp_first_sample", 32'(sample), 32'h11);
    wait_overrun("bp_overrun_set", 400);
    enable = 1'b0;
    wait_busy("bp_idle", 1'b0, 200);
    check("bp_sample_held", 32'(sample), 32'h11);
    check("bp_valid_held", 32'(sample_valid), 32'd1);
    check("bp_overrun_sticky", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("bp_overrun_cleared", 32'(overrun), 32'd0);
    check("bp_sample_before_accept", 32'(sample), 32'h11);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("bp_valid_after_accept", 32'(sample_valid), 32'd0);
    repeat (20) @(negedge clk);
    check("bp_no_second_word", 32'(sample_valid), 32'd0);

    // Accept in the very clk the second word completes
    adc_words.push_back(8'h33);
    adc_words.push_back(8'h44);
    enable = 1'b1;
    wait_valid("sim_first_valid", 300);
    check("sim_first_sample", 32'(sample), 32'h33);
    wait_cs("sim_second_cs_low", 1'b0, 200);
    enable = 1'b0;
    count_rises("sim_ten_rises", 10, 200);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("sim_valid_stays", 32'(sample_valid), 32'd1);
    check("sim_sample_second", 32'(sample), 32'h44);
    check("sim_no_overrun", 32'(overrun), 32'd0);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("sim_second_accepted", 32'(sample_valid), 32'd0);
    wait_busy("sim_idle", 1'b0, 200);

    // Reset after four data bits, then a clean conversion
    sample_ready = 1'b1;
    adc_words.push_back(8'hC3);
    enable = 1'b1;
    wait_cs("rm_cs_low", 1'b0, 200);
    enable = 1'b0;
    count_rises("rm_lead_plus_4_bits", 6, 100);
    rst = 1'b0;
    #1;
    check("rm_cs_n_async", 32'(adc_cs_n), 32'd1);
    check("rm_valid", 32'(sample_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_sample_cleared", 32'(sample), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    adc_words.push_back(8'h5A);
    enable = 1'b1;
    wait_busy("rm_restart", 1'b1, 20);
    enable = 1'b0;
    wait_valid("rm_next_valid", 300);
    check("rm_next_sample", 32'(sample), 32'h5A);
    wait_busy("rm_idle", 1'b0, 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
